// File: rtl/grf_pkg.sv
// Shared constants and slice helper for the scoreboarded register file.
// Latency: n/a (package only).
// Backpressure: n/a.
package grf_pkg;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ADDR_W = 5;
   localparam int DEFAULT_CNT_W  = 2;
   localparam int DEFAULT_NUM_RD = 2;

   // Register index that is hard-wired to zero when ZERO_REG is enabled.
   localparam int ZERO_ADDR = 0;

   // Low bit of port 'port' inside a bus that packs ports of 'width' bits
   // side by side, port 0 in the least significant slice.
   function automatic int slice_lo(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/grf_scoreboarded_if.sv
// Bundle of read, write, issue, scoreboard and trace signals of the register file.
// Latency: n/a (wires only).
// Backpressure: none; every signal is sampled or driven each cycle.
interface grf_scoreboarded_if
   import grf_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int NUM_RD = DEFAULT_NUM_RD
) ();

   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;

   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;

   logic                     issue_en;
   logic [ADDR_W-1:0]        issue_addr;

   logic [(1<<ADDR_W)-1:0]   busy_vec;
   logic                     sb_overflow;

   logic                     trace_valid;
   logic [ADDR_W-1:0]        trace_addr;
   logic [DATA_W-1:0]        trace_data;

   // Pipeline side: drives addresses, writes and reservations.
   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
      input  rd_data, rd_busy, busy_vec, sb_overflow,
      input  trace_valid, trace_addr, trace_data
   );

   // Register file side.
   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
      output rd_data, rd_busy, busy_vec, sb_overflow,
      output trace_valid, trace_addr, trace_data
   );

endinterface

// File: rtl/grf_scoreboard.sv
// Per-register pending-write counters: issue reserves, write releases.
// Latency: counts update at posedge; busy vectors are the registered counts.
// Backpressure: none; saturating counter sets a sticky overflow flag instead.
module grf_scoreboard
   import grf_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int CNT_W  = DEFAULT_CNT_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   issue,
   input  logic [ADDR_W-1:0]      issue_addr,
   input  logic                   write,
   input  logic [ADDR_W-1:0]      wr_addr,
   output logic [(1<<ADDR_W)-1:0] busy_vec,
   output logic [(1<<ADDR_W)-1:0] dec_busy_vec,
   output logic                   sb_overflow
);

   localparam int               DEPTH   = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt [DEPTH];
   logic [DEPTH-1:0] inc_vec;
   logic [DEPTH-1:0] dec_vec;
   logic             ovf_hit;

   // One-hot decode of the issue and write targets; a reservation on a saturated
   // counter overflows unless a write to the same register cancels it out.
   always_comb begin
      inc_vec             = '0;
      dec_vec             = '0;
      inc_vec[issue_addr] = issue;
      dec_vec[wr_addr]    = write;
      ovf_hit = issue && !(write && (wr_addr == issue_addr))
                && (cnt[issue_addr] == CNT_MAX);
   end

   // Counter update: +1 on issue (saturating), -1 on write (floored at 0),
   // unchanged when both hit the same register.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            cnt[r] <= '0;
         end
         sb_overflow <= 1'b0;
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            case ({inc_vec[r], dec_vec[r]})
               2'b10: if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + 1'b1;
               2'b01: if (cnt[r] != '0)      cnt[r] <= cnt[r] - 1'b1;
               default: ;
            endcase
         end
         if (ovf_hit) begin
            sb_overflow <= 1'b1;
         end
      end
   end

   // Busy views: count nonzero, and count still nonzero after one release
   // (used when a read is bypassed from the write in flight).
   always_comb begin
      busy_vec     = '0;
      dec_busy_vec = '0;
      for (int r = 0; r < DEPTH; r++) begin
         busy_vec[r]     = (cnt[r] != '0);
         dec_busy_vec[r] = (cnt[r] > CNT_W'(1));
      end
   end

endmodule

// File: rtl/grf_scoreboarded.sv
// General register file: N combinational reads, one write, optional bypass, pending-write scoreboard.
// Latency: reads 0 cycles; stored value and counts update at posedge; trace 1 cycle after write.
// Backpressure: none; callers stall on rd_busy / busy_vec.
module grf_scoreboarded
   import grf_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int NUM_RD   = DEFAULT_NUM_RD,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int CNT_W    = DEFAULT_CNT_W
) (
   input logic               clk,
   input logic               reset,
   grf_scoreboarded_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0]        mem [DEPTH];
   logic                     wr_eff;
   logic                     issue_eff;
   logic [DEPTH-1:0]         count_nz;
   logic [DEPTH-1:0]         dec_nz;
   logic                     overflow;
   logic [ADDR_W-1:0]        rd_sel [NUM_RD];
   logic [NUM_RD*DATA_W-1:0] rd_data_mux;
   logic [NUM_RD-1:0]        rd_busy_mux;
   logic                     trace_valid_q;
   logic [ADDR_W-1:0]        trace_addr_q;
   logic [DATA_W-1:0]        trace_data_q;

   // Writes and reservations aimed at the hard-wired zero register are discarded.
   always_comb begin
      wr_eff    = bus.wr_en
                  && !((ZERO_REG != 0) && (bus.wr_addr == ADDR_W'(ZERO_ADDR)));
      issue_eff = bus.issue_en
                  && !((ZERO_REG != 0) && (bus.issue_addr == ADDR_W'(ZERO_ADDR)));
   end

   grf_scoreboard #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_sb (
      .clk          (clk),
      .reset        (reset),
      .issue        (issue_eff),
      .issue_addr   (bus.issue_addr),
      .write        (wr_eff),
      .wr_addr      (bus.wr_addr),
      .busy_vec     (count_nz),
      .dec_busy_vec (dec_nz),
      .sb_overflow  (overflow)
   );

   // Storage array: cleared by reset, otherwise takes the effective write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            mem[r] <= '0;
         end
      end else if (wr_eff) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Split the packed read-address bus into per-port selects.
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         rd_sel[i] = bus.rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
      end
   end

   // Read muxes: zero register first, then same-cycle bypass, then stored value.
   always_comb begin
      rd_data_mux = '0;
      rd_busy_mux = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if ((ZERO_REG != 0) && (rd_sel[i] == ADDR_W'(ZERO_ADDR))) begin
            rd_data_mux[slice_lo(i, DATA_W) +: DATA_W] = '0;
            rd_busy_mux[i] = 1'b0;
         end else if ((BYPASS != 0) && wr_eff && (bus.wr_addr == rd_sel[i])) begin
            rd_data_mux[slice_lo(i, DATA_W) +: DATA_W] = bus.wr_data;
            rd_busy_mux[i] = dec_nz[rd_sel[i]];
         end else begin
            rd_data_mux[slice_lo(i, DATA_W) +: DATA_W] = mem[rd_sel[i]];
            rd_busy_mux[i] = count_nz[rd_sel[i]];
         end
      end
   end

   // Trace register: one pulse per committed write, holding address/data otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         trace_valid_q <= 1'b0;
         trace_addr_q  <= '0;
         trace_data_q  <= '0;
      end else begin
         trace_valid_q <= wr_eff;
         if (wr_eff) begin
            trace_addr_q <= bus.wr_addr;
            trace_data_q <= bus.wr_data;
         end
      end
   end

   assign bus.rd_data     = rd_data_mux;
   assign bus.rd_busy     = rd_busy_mux;
   assign bus.busy_vec    = count_nz;
   assign bus.sb_overflow = overflow;
   assign bus.trace_valid = trace_valid_q;
   assign bus.trace_addr  = trace_addr_q;
   assign bus.trace_data  = trace_data_q;

endmodule

// File: tb/tb_grf_scoreboarded.sv
// Bench for grf_scoreboarded: bypass and non-bypass instances share one stimulus stream.
// Latency: reference model updated on posedge, outputs compared on negedge.
// Backpressure: none.
module tb_grf_scoreboarded;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int CW    = 2;
   localparam int DEPTH = 1 << AW;
   localparam int CMAX  = (1 << CW) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [NR*AW-1:0] rd_addr;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic             issue_en;
   logic [AW-1:0]    issue_addr;

   grf_scoreboarded_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) if_b1 ();
   grf_scoreboarded_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) if_b0 ();

   assign if_b1.rd_addr    = rd_addr;
   assign if_b1.wr_en      = wr_en;
   assign if_b1.wr_addr    = wr_addr;
   assign if_b1.wr_data    = wr_data;
   assign if_b1.issue_en   = issue_en;
   assign if_b1.issue_addr = issue_addr;
   assign if_b0.rd_addr    = rd_addr;
   assign if_b0.wr_en      = wr_en;
   assign if_b0.wr_addr    = wr_addr;
   assign if_b0.wr_data    = wr_data;
   assign if_b0.issue_en   = issue_en;
   assign if_b0.issue_addr = issue_addr;

   grf_scoreboarded #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1), .CNT_W(CW))
      dut_b1 (.clk(clk), .reset(reset), .bus(if_b1.slave));
   grf_scoreboarded #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0), .CNT_W(CW))
      dut_b0 (.clk(clk), .reset(reset), .bus(if_b0.slave));

   // Reference model: register contents, pending counts, sticky flag, last trace.
   logic [DW-1:0] m_reg [DEPTH];
   int            m_cnt [DEPTH];
   bit            m_ovf;
   bit            m_tv;
   logic [AW-1:0] m_ta;
   logic [DW-1:0] m_td;
   bit            model_live = 1'b0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model state advance, using the inputs present at this posedge.
   always @(posedge clk) begin : model_upd
      bit we;
      bit ie;
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
         end
         m_ovf      = 1'b0;
         m_tv       = 1'b0;
         m_ta       = '0;
         m_td       = '0;
         model_live = 1'b1;
      end else begin
         we = wr_en && (wr_addr != 0);
         ie = issue_en && (issue_addr != 0);
         m_tv = we;
         if (we) begin
            m_ta = wr_addr;
            m_td = wr_data;
            m_reg[wr_addr] = wr_data;
         end
         if (!(we && ie && (wr_addr == issue_addr))) begin
            if (we && m_cnt[wr_addr] > 0) m_cnt[wr_addr] = m_cnt[wr_addr] - 1;
            if (ie) begin
               if (m_cnt[issue_addr] == CMAX) m_ovf = 1'b1;
               else m_cnt[issue_addr] = m_cnt[issue_addr] + 1;
            end
         end
      end
   end

   task automatic compare(input string tag, input bit byp,
                          input logic [NR*DW-1:0] rdd, input logic [NR-1:0] rdb,
                          input logic [DEPTH-1:0] bv, input logic ovf,
                          input logic tv, input logic [AW-1:0] ta, input logic [DW-1:0] td);
      logic [AW-1:0]    a;
      logic [DW-1:0]    ed;
      logic             eb;
      logic [DEPTH-1:0] ebv;
      int               left;
      for (int i = 0; i < NR; i++) begin
         a = rd_addr[i*AW +: AW];
         if (a == 0) begin
            ed = '0;
            eb = 1'b0;
         end else if (byp && wr_en && (wr_addr != 0) && (wr_addr == a)) begin
            left = (m_cnt[a] > 0) ? m_cnt[a] - 1 : 0;
            ed = wr_data;
            eb = (left != 0);
         end else begin
            ed = m_reg[a];
            eb = (m_cnt[a] != 0);
         end
         chk($sformatf("%s rd_data%0d", tag, i), rdd[i*DW +: DW], ed);
         chk($sformatf("%s rd_busy%0d", tag, i), rdb[i], eb);
      end
      for (int r = 0; r < DEPTH; r++) ebv[r] = (m_cnt[r] != 0);
      chk({tag, " busy_vec"}, bv, ebv);
      chk({tag, " sb_overflow"}, ovf, m_ovf);
      chk({tag, " trace_valid"}, tv, m_tv);
      if (m_tv) begin
         chk({tag, " trace_addr"}, ta, m_ta);
         chk({tag, " trace_data"}, td, m_td);
      end
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (model_live) begin
         compare("byp1", 1'b1, if_b1.rd_data, if_b1.rd_busy, if_b1.busy_vec,
                 if_b1.sb_overflow, if_b1.trace_valid, if_b1.trace_addr, if_b1.trace_data);
         compare("byp0", 1'b0, if_b0.rd_data, if_b0.rd_busy, if_b0.busy_vec,
                 if_b0.sb_overflow, if_b0.trace_valid, if_b0.trace_addr, if_b0.trace_data);
      end
   end

   task automatic idle();
      wr_en    = 1'b0;
      issue_en = 1'b0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;

      // Reset with a simultaneous write and issue to r4: both dropped.
      rd_addr = '0; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hCAFE_F00D;
      issue_en = 1'b1; issue_addr = 5'd4;
      next();
      @(negedge clk);
      chk("rst busy_vec", if_b1.busy_vec, 32'h0);
      chk("rst sb_overflow", if_b1.sb_overflow, 1'b0);
      chk("rst trace_valid", if_b1.trace_valid, 1'b0);
      chk("rst trace_addr", if_b1.trace_addr, 5'd0);
      chk("rst trace_data", if_b1.trace_data, 32'h0);
      next();
      reset = 1'b0;
      idle();

      // Write r5, read back on both ports next cycle, trace one cycle later.
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678; rd_addr = {5'd5, 5'd5};
      next();
      idle();
      @(negedge clk);
      chk("r5 data p0", if_b1.rd_data[31:0], 32'h1234_5678);
      chk("r5 data p1", if_b0.rd_data[63:32], 32'h1234_5678);
      chk("r5 busy", if_b1.rd_busy, 2'b00);
      chk("r5 trace_valid", if_b1.trace_valid, 1'b1);
      chk("r5 trace_addr", if_b1.trace_addr, 5'd5);
      chk("r5 trace_data", if_b1.trace_data, 32'h1234_5678);
      next();

      // r0 ignores writes and issues.
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = '1; rd_addr = {5'd0, 5'd0};
      next();
      idle();
      issue_en = 1'b1; issue_addr = 5'd0;
      @(negedge clk);
      chk("r0 no trace", if_b1.trace_valid, 1'b0);
      next();
      idle();
      @(negedge clk);
      chk("r0 data", if_b1.rd_data[31:0], 32'h0);
      chk("r0 busy_vec0", if_b1.busy_vec[0], 1'b0);

      // r7: reserve, then write while reading.
      next();
      issue_en = 1'b1; issue_addr = 5'd7;
      next();
      idle();
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_A5A5; rd_addr = {5'd7, 5'd7};
      @(negedge clk);
      chk("r7 byp data", if_b1.rd_data[31:0], 32'h0000_A5A5);
      chk("r7 byp busy", if_b1.rd_busy[0], 1'b0);
      chk("r7 nobyp data", if_b0.rd_data[31:0], 32'h0);
      chk("r7 nobyp busy", if_b0.rd_busy[0], 1'b1);
      next();
      idle();

      // r3: saturate and overflow, then drain without underflow.
      issue_en = 1'b1; issue_addr = 5'd3; rd_addr = {5'd3, 5'd3};
      repeat (3) next();
      @(negedge clk);
      chk("r3 ovf before", if_b1.sb_overflow, 1'b0);
      next();
      idle();
      @(negedge clk);
      chk("r3 ovf", if_b1.sb_overflow, 1'b1);
      chk("r3 busy_vec", if_b1.busy_vec[3], 1'b1);
      chk("model cnt3 sat", m_cnt[3], 64'd3);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h3333;
      repeat (3) next();
      idle();
      @(negedge clk);
      chk("r3 drained", if_b1.busy_vec[3], 1'b0);
      chk("model cnt3 zero", m_cnt[3], 64'd0);
      wr_en = 1'b1;
      next();
      idle();
      issue_en = 1'b1;
      next();
      idle();
      wr_en = 1'b1;
      next();
      idle();
      @(negedge clk);
      chk("r3 no underflow", if_b1.busy_vec[3], 1'b0);

      // r9: issue and write same cycle at count 1.
      issue_en = 1'b1; issue_addr = 5'd9;
      next();
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; rd_addr = {5'd9, 5'd9};
      @(negedge clk);
      chk("r9 byp busy", if_b1.rd_busy[1], 1'b0);
      chk("r9 byp data", if_b1.rd_data[63:32], 32'h99);
      chk("r9 nobyp busy", if_b0.rd_busy[1], 1'b1);
      next();
      idle();
      @(negedge clk);
      chk("r9 busy_vec", if_b1.busy_vec[9], 1'b1);
      wr_en = 1'b1;
      next();
      idle();

      // Random traffic with address collisions and occasional reset.
      for (int n = 0; n < 3000; n++) begin
         reset      = ($urandom_range(0, 249) == 0);
         wr_en      = ($urandom_range(0, 99) < 45);
         wr_addr    = AW'($urandom_range(0, 15));
         wr_data    = $urandom;
         issue_en   = ($urandom_range(0, 99) < 40);
         issue_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 15));
         a0 = ($urandom_range(0, 1) == 1) ? wr_addr : AW'($urandom_range(0, 15));
         a1 = ($urandom_range(0, 1) == 1) ? issue_addr : AW'($urandom_range(0, 31));
         rd_addr = {a1, a0};
         next();
      end
      reset = 1'b0;
      idle();

      // Final reset with a simultaneous write and issue to r4.
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_DEAD;
      next();
      idle();
      issue_en = 1'b1; issue_addr = 5'd4;
      repeat (2) next();
      issue_addr = 5'd12;
      repeat (5) next();
      idle();
      @(negedge clk);
      chk("pre-reset ovf", if_b1.sb_overflow, 1'b1);
      reset = 1'b1;
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_BEEF;
      issue_en = 1'b1; issue_addr = 5'd4; rd_addr = {5'd4, 5'd4};
      next();
      reset = 1'b0;
      idle();
      @(negedge clk);
      chk("rst4 data", if_b1.rd_data[31:0], 32'h0);
      chk("rst4 busy_vec", if_b1.busy_vec, 32'h0);
      chk("rst4 trace_valid", if_b1.trace_valid, 1'b0);
      chk("rst4 sb_overflow", if_b1.sb_overflow, 1'b0);
      next();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
